// File: rtl/two_a_plus_b_pkg.sv
// two_a_plus_b_pkg: shared state encoding and default sizing for the 2A+B scheduler
package two_a_plus_b_pkg;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_REQ = 4;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PASS_A = 2'd1,
    PASS_B = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple adder with carry in and carry out
module full_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  output logic [WIDTH-1:0] S,
  output logic             C_OUT
);
  assign {C_OUT, S} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C_IN};
endmodule

// File: rtl/two_a_plus_b_seq_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from PTR+1 with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [ID_W-1:0]    PTR,
  input  logic               EN,
  output logic [NUM_REQ-1:0] GNT,
  output logic [ID_W-1:0]    GNT_IDX
);
  logic [NUM_REQ-1:0] sel;
  int j;
  // walk candidates farthest-first so the nearest valid requester after PTR wins last
  always_comb begin
    GNT = '0;
    GNT_IDX = '0;
    sel = '0;
    j = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(PTR) + k) % NUM_REQ;
      sel = NUM_REQ'(1) << j;
      if (EN && |(REQ & sel)) begin
        GNT = sel;
        GNT_IDX = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/two_a_plus_b_seq.sv
// two_a_plus_b_seq: shares one adder across requesters to compute (2A+B) mod 2^WIDTH over two passes
// Optional overflow flag output OVF is built when TWO_A_PLUS_B_SEQ_OVF_EN is defined.
module two_a_plus_b_seq
  import two_a_plus_b_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     CLK,
  input  logic                     N_RST,
  input  logic [NUM_REQ-1:0]       REQ_VALID,
  output logic [NUM_REQ-1:0]       REQ_READY,
  input  logic [NUM_REQ*WIDTH-1:0] REQ_A,
  input  logic [NUM_REQ*WIDTH-1:0] REQ_B,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [WIDTH-1:0]         OUT,
  output logic [ID_W-1:0]          OUT_ID,
  output logic                     BUSY
`ifdef TWO_A_PLUS_B_SEQ_OVF_EN
  ,
  output logic                     OVF
`endif
);
  state_t state;
  logic [ID_W-1:0] ptr, id, gnt_idx, out_id_q;
  logic [WIDTH-1:0] a_q, b_q, acc, out_q, add_x, add_y, sum;
  logic hs;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .REQ(REQ_VALID),
    .PTR(ptr),
    .EN(state == IDLE),
    .GNT(REQ_READY),
    .GNT_IDX(gnt_idx)
  );
  assign hs = (state == IDLE) && |REQ_READY;
  // pass A doubles the captured A, pass B adds B onto the partial sum
  assign add_x = (state == PASS_A) ? a_q : acc;
  assign add_y = (state == PASS_A) ? a_q : b_q;
`ifdef TWO_A_PLUS_B_SEQ_OVF_EN
  logic carry, c1, c2, ovf_q;
  full_adder #(.WIDTH(WIDTH)) u_add (.A(add_x), .B(add_y), .C_IN(1'b0), .S(sum), .C_OUT(carry));
  // carries of each pass; the flag is latched alongside the result
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      c1 <= 1'b0;
      c2 <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state == PASS_A) begin
      c1 <= carry;
    end else if (state == PASS_B) begin
      c2 <= carry;
      ovf_q <= c1 | carry;
    end
  end
  assign OVF = ovf_q;
`else
  logic carry_unused;
  full_adder #(.WIDTH(WIDTH)) u_add (.A(add_x), .B(add_y), .C_IN(1'b0), .S(sum), .C_OUT(carry_unused));
`endif
  // FSM plus operand capture; the result register holds its value after DONE until the next result
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state <= IDLE;
      ptr <= ID_W'(NUM_REQ - 1);
      id <= '0;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      out_q <= '0;
      out_id_q <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          a_q <= REQ_A[gnt_idx*WIDTH +: WIDTH];
          b_q <= REQ_B[gnt_idx*WIDTH +: WIDTH];
          id <= gnt_idx;
          ptr <= gnt_idx;
          state <= PASS_A;
        end
        PASS_A: begin
          acc <= sum;
          state <= PASS_B;
        end
        PASS_B: begin
          acc <= sum;
          out_q <= sum;
          out_id_q <= id;
          state <= DONE;
        end
        default: if (OUT_READY) state <= IDLE;
      endcase
    end
  end
  assign OUT_VALID = state == DONE;
  assign BUSY = state != IDLE;
  assign OUT = out_q;
  assign OUT_ID = (NUM_REQ == 1) ? '0 : out_id_q;
`ifdef FORMAL
  a_result: assert property (@(posedge CLK) disable iff (!N_RST)
    state == DONE |-> OUT == WIDTH'(2 * 32'(a_q) + 32'(b_q)));
  a_onehot: assert property (@(posedge CLK) disable iff (!N_RST) $onehot0(REQ_READY));
  a_stable: assert property (@(posedge CLK) disable iff (!N_RST)
    OUT_VALID && !OUT_READY |=> $stable(OUT));
`endif
endmodule

// File: tb/tb_two_a_plus_b_seq.sv
// tb_two_a_plus_b_seq: randomized self-checking bench against a round-robin/arithmetic reference model
module tb_two_a_plus_b_seq;
  logic clk = 1'b0;
  logic n_rst;
  logic [3:0] req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic out_valid, out_ready, busy;
  logic [7:0] out;
  logic [1:0] out_id;
`ifdef TWO_A_PLUS_B_SEQ_OVF_EN
  logic ovf;
`endif
  int checks = 0;
  int errors = 0;
  int model_ptr = 3;

  always #5 clk = ~clk;

  two_a_plus_b_seq #(.WIDTH(8), .NUM_REQ(4)) dut (
    .CLK(clk),
    .N_RST(n_rst),
    .REQ_VALID(req_valid),
    .REQ_READY(req_ready),
    .REQ_A(req_a),
    .REQ_B(req_b),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .OUT(out),
    .OUT_ID(out_id),
    .BUSY(busy)
`ifdef TWO_A_PLUS_B_SEQ_OVF_EN
    ,
    .OVF(ovf)
`endif
  );

  function automatic int rr_pick(int p, logic [3:0] m);
    for (int k = 1; k <= 4; k++)
      if (((m >> ((p + k) % 4)) & 4'd1) != 4'd0) return (p + k) % 4;
    return -1;
  endfunction

  function automatic int oh_idx(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v == (4'd1 << i)) return i;
    return -1;
  endfunction

  function automatic int ref_out(int a, int b);
    return (2 * a + b) % 256;
  endfunction

  function automatic int ref_ovf(int a, int b);
    return (2 * a + b > 255) ? 1 : 0;
  endfunction

  // drive one request mask, wait for grant, then wait for the result; returns at a negedge with OUT_VALID high
  task automatic xact(input logic [3:0] mask, input logic [31:0] aa, input logic [31:0] bb,
                      output int g, output int lat, output bit to);
    @(negedge clk);
    req_valid = mask;
    req_a = aa;
    req_b = bb;
    out_ready = 1'b1;
    g = -1;
    lat = 0;
    to = 1'b1;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (req_ready != 4'd0) begin
        g = oh_idx(req_ready);
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (to) begin
      req_valid = 4'd0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'd0;
    lat = 1;
    to = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (out_valid) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && busy; t++) @(negedge clk);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    req_valid = 4'd0;
    req_a = '0;
    req_b = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b busy=%b ready=%b want 0 0 0000", out_valid, busy, req_ready);
    end
    checks++;
    if (out !== 8'd0 || out_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_data: got out=%0h id=%0d want 0 0", out, out_id);
    end
`ifdef TWO_A_PLUS_B_SEQ_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    n_rst = 1'b1;
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b want 0001", req_ready);
    end
    req_valid = 4'd0;
    model_ptr = 3;
  endtask

  task automatic test_single();
    bit exp_b, exp_v;
    @(negedge clk);
    req_valid = 4'b0001;
    req_a = 32'd3;
    req_b = 32'd4;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: got %b want 0001", req_ready);
    end
    model_ptr = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'd0;
    req_a = 32'hFFFF_FFFF;
    for (int i = 1; i <= 4; i++) begin
      exp_b = i <= 3;
      exp_v = i == 3;
      checks++;
      if (busy !== exp_b || out_valid !== exp_v || req_ready !== 4'd0) begin
        errors++;
        $display("FAIL single_timing[%0d]: got busy=%b valid=%b ready=%b want %b %b 0000",
                 i, busy, out_valid, req_ready, exp_b, exp_v);
      end
      if (i >= 3) begin
        checks++;
        if (out !== 8'd10 || out_id !== 2'd0) begin
          errors++;
          $display("FAIL single_result[%0d]: got out=%0d id=%0d want 10 0", i, out, out_id);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    int g, lat, e;
    bit to;
    logic [31:0] aa, bb;
    int av[2] = '{255, 127};
    int bv[2] = '{2, 1};
    for (int n = 0; n < 2; n++) begin
      aa = 32'(av[n]) << 8;
      bb = 32'(bv[n]) << 8;
      xact(4'b0010, aa, bb, g, lat, to);
      e = rr_pick(model_ptr, 4'b0010);
      model_ptr = e;
      checks++;
      if (to || g != e || lat != 3) begin
        errors++;
        $display("FAIL wrap_handshake[%0d]: got to=%b gnt=%0d lat=%0d want 0 %0d 3", n, to, g, lat, e);
      end
      checks++;
      if (32'(out) != 32'(ref_out(av[n], bv[n])) || out_id !== 2'd1) begin
        errors++;
        $display("FAIL wrap_result[%0d]: got out=%0h id=%0d want %0h 1", n, out, out_id, ref_out(av[n], bv[n]));
      end
`ifdef TWO_A_PLUS_B_SEQ_OVF_EN
      checks++;
      if (32'(ovf) != 32'(ref_ovf(av[n], bv[n]))) begin
        errors++;
        $display("FAIL wrap_ovf[%0d]: got %b want %0d", n, ovf, ref_ovf(av[n], bv[n]));
      end
`endif
    end
  endtask

  task automatic rr_phase(input logic [3:0] mask, input string tag);
    int g, e;
    bit found;
    @(negedge clk);
    req_valid = mask;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      found = 1'b0;
      for (int t = 0; t < 20; t++) begin
        #1;
        if (req_ready != 4'd0) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      g = oh_idx(req_ready);
      e = rr_pick(model_ptr, mask);
      model_ptr = e;
      checks++;
      if (!found || g != e) begin
        errors++;
        $display("FAIL rr_%s[%0d]: got gnt=%0d want %0d", tag, n, g, e);
      end
      @(negedge clk);
    end
    req_valid = 4'd0;
    drain();
  endtask

  task automatic test_round_robin();
    req_a = 32'h0403_0201;
    req_b = 32'h0807_0605;
    rr_phase(4'b0101, "pair");
    rr_phase(4'b1111, "all");
  endtask

  task automatic test_backpressure();
    logic [7:0] a1, b1, a2, b2, snap;
    logic [1:0] snap_id;
    int e;
    bit to;
    a1 = 8'($urandom);
    b1 = 8'($urandom);
    a2 = 8'($urandom);
    b2 = 8'($urandom);
    @(negedge clk);
    out_ready = 1'b0;
    req_a = {8'd0, a2, a1, 8'd0};
    req_b = {8'd0, b2, b1, 8'd0};
    req_valid = 4'b0010;
    e = rr_pick(model_ptr, 4'b0010);
    model_ptr = e;
    @(negedge clk);
    req_valid = 4'b0100;
    to = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (out_valid) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    snap = out;
    snap_id = out_id;
    checks++;
    if (to || 32'(snap) != 32'(ref_out(32'(a1), 32'(b1))) || snap_id !== 2'(e)) begin
      errors++;
      $display("FAIL bp_result: got to=%b out=%0h id=%0d want 0 %0h %0d", to, snap, snap_id, ref_out(32'(a1), 32'(b1)), e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out !== snap || out_id !== snap_id || req_ready !== 4'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b out=%0h id=%0d ready=%b want 1 %0h %0d 0000",
                 i, out_valid, out, out_id, req_ready, snap, snap_id);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'd0) begin
      errors++;
      $display("FAIL bp_no_same_cycle: got ready=%b want 0000", req_ready);
    end
    @(negedge clk);
    #1;
    e = rr_pick(model_ptr, 4'b0100);
    model_ptr = e;
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_next_accept: got valid=%b ready=%b want 0 0100", out_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 4'd0;
    to = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (out_valid) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (to || 32'(out) != 32'(ref_out(32'(a2), 32'(b2))) || out_id !== 2'd2) begin
      errors++;
      $display("FAIL bp_second: got to=%b out=%0h id=%0d want 0 %0h 2", to, out, out_id, ref_out(32'(a2), 32'(b2)));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int g, lat;
    bit to;
    @(negedge clk);
    req_valid = 4'b0001;
    req_a = 32'h0000_0055;
    req_b = 32'h0000_0011;
    out_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'd0;
    @(negedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'd0 || out !== 8'd0 || out_id !== 2'd0) begin
      errors++;
      $display("FAIL midop_reset: got valid=%b busy=%b ready=%b out=%0h id=%0d want all 0",
               out_valid, busy, req_ready, out, out_id);
    end
    model_ptr = 3;
    @(negedge clk);
    n_rst = 1'b1;
    xact(4'b1000, 32'h0100_0000, 32'h0100_0000, g, lat, to);
    checks++;
    if (to || g != rr_pick(model_ptr, 4'b1000) || lat != 3 || out !== 8'd3 || out_id !== 2'd3) begin
      errors++;
      $display("FAIL midop_after: got to=%b gnt=%0d lat=%0d out=%0h id=%0d want 0 3 3 3 3", to, g, lat, out, out_id);
    end
    model_ptr = 3;
  endtask

  task automatic test_random();
    int g, lat, e, ea, eb, bad;
    bit to;
    logic [3:0] mask;
    logic [31:0] aa, bb;
    bad = 0;
    for (int n = 0; n < 1500; n++) begin
      mask = 4'($urandom_range(1, 15));
      aa = $urandom;
      bb = $urandom;
      if (n < 4) begin
        aa = (n % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF;
        bb = (n < 2) ? 32'h0 : 32'hFFFF_FFFF;
      end
      e = rr_pick(model_ptr, mask);
      model_ptr = e;
      ea = 32'((aa >> (8 * e)) & 32'hFF);
      eb = 32'((bb >> (8 * e)) & 32'hFF);
      xact(mask, aa, bb, g, lat, to);
      checks++;
      if (to || g != e || lat != 3 || 32'(out) != 32'(ref_out(ea, eb)) || 32'(out_id) != e) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random[%0d]: got to=%b gnt=%0d lat=%0d out=%0h id=%0d want 0 %0d 3 %0h %0d",
                   n, to, g, lat, out, out_id, e, ref_out(ea, eb), e);
      end
`ifdef TWO_A_PLUS_B_SEQ_OVF_EN
      checks++;
      if (32'(ovf) != 32'(ref_ovf(ea, eb))) begin
        errors++;
        $display("FAIL random_ovf[%0d]: got %b want %0d", n, ovf, ref_ovf(ea, eb));
      end
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
